fetch_queue_unit: RTL
=====================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of all PC and address signals.
REQ-002 Parameter FQ_DEPTH, default 4, fetch-queue entries; SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 pc_sel  in  1  redirect request from execute (branch/jump taken).
REQ-007 pc_target  in  ADDR_W  redirect address, sampled when pc_sel=1.
REQ-008 stall_d  in  1  decode cannot accept an instruction this cycle.
REQ-009 imem_req_valid  out  1  fetch request offered to instruction memory.
REQ-010 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-011 imem_req_addr  out  ADDR_W  word-aligned request address.
REQ-012 imem_rsp_valid  in  1  instruction word returned, strictly in request order.
REQ-013 imem_rsp_data  in  32  returned instruction word.
REQ-014 valid_d  out  1  instr_d/pc_d/pc_next_d hold a real instruction.
REQ-015 instr_d  out  32  instruction to decode.
REQ-016 pc_d  out  ADDR_W  address of instr_d.
REQ-017 pc_next_d  out  ADDR_W  pc_d+4.

Function
REQ-018 Fetch PC register SHALL advance by 4 (mod 2^ADDR_W, wrap from all-ones-word to 0) on each cycle with imem_req_valid=1 and imem_req_ready=1.
REQ-019 imem_req_addr SHALL equal the fetch PC; bits [1:0] always 0.
REQ-020 Each accepted request SHALL allocate one queue entry {pc, instr, filled=0} at the allocation pointer.
REQ-021 Each imem_rsp_valid=1 cycle not consumed by drop_cnt SHALL write imem_rsp_data into the oldest unfilled entry and set filled=1.
REQ-022 imem_req_valid SHALL be 1 iff allocated entries + drop_cnt < FQ_DEPTH and pc_sel=0.
REQ-023 valid_d SHALL be 1 iff head entry is filled and pc_sel=0; outputs driven from head entry registers, no combinational path from imem_rsp_*.
REQ-024 Head SHALL dequeue on valid_d=1 and stall_d=0; with stall_d=1 all outputs hold.
REQ-025 Minimum latency: response in cycle r -> valid_d=1 in cycle r+1.
REQ-026 With valid_d=0, instr_d, pc_d, pc_next_d SHALL be 0 (NOP bubble).
REQ-027 pc_sel=1: all entries flushed; fetch PC <= {pc_target[ADDR_W-1:2],2'b00}; drop_cnt <= unfilled entries minus (1 if imem_rsp_valid that cycle); that response discarded.
REQ-028 While drop_cnt>0 each response SHALL be discarded and decrement drop_cnt; new requests permitted per REQ-022.
REQ-029 pc_sel has priority over stall_d, dequeue, fill and allocation in the same cycle.
REQ-030 Simultaneous allocate, fill and dequeue in one cycle SHALL all take effect; full queue with dequeue does not permit same-cycle allocation.
REQ-031 A response with no unfilled entry and drop_cnt=0 SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately clear: fetch PC=RESET_PC, pointers=0, all filled=0, drop_cnt=0, valid_d=0, instr_d/pc_d/pc_next_d=0, imem_req_valid=0.
REQ-033 First request SHALL be offered in the first cycle after rst deasserts; instruction memory SHALL share rst so no pre-reset response arrives.

Structure
REQ-034 Package fetch_pkg SHALL hold INSTR_W=32, NOP_INSTR=32'h0, PC_INCR=4 and the queue-entry record type.
REQ-035 Sub-module fetch_entry_queue SHALL implement the circular buffer with alloc, fill, head pointers and flush; fetch_queue_unit holds fetch PC, drop_cnt and handshake logic.

Verification
REQ-036 Reset release, ready=1, 1-cycle memory, stall_d=0 -> requests 0x0,0x4,0x8...; valid_d from cycle 2; pc_d 0x0,0x4,... one per cycle; pc_next_d=pc_d+4.
REQ-037 stall_d=1 for 5 cycles with FQ_DEPTH=4 -> imem_req_valid drops after 4 allocations; outputs hold pc_d=0x0; release drains 0x0..0xC in order, no loss.
REQ-038 3 requests in flight, pc_sel=1 with pc_target=0x103 -> next request 0x100; 3 stale responses discarded; first valid_d shows pc_d=0x100.
REQ-039 pc_sel=1 same cycle as rsp_valid and stall_d=1 -> response dropped, drop_cnt=inflight-1, valid_d=0 next cycle.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-041 rst asserted mid-stream with full queue -> outputs zero immediately, restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue slot record for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned        INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned        PC_INCR   = 4;

  // One fetch-queue slot. The slot PC is stored beside the record because its width is a module parameter.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-side handshakes: execute redirect, decode handoff and the instruction-memory request/response channel.
interface fetch_queue_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic               pc_sel;
  logic [ADDR_W-1:0]  pc_target;
  logic               stall_d;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               valid_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  pc_next_d;

  modport master (
    input  pc_sel, pc_target, stall_d, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, valid_d, instr_d, pc_d, pc_next_d
  );

  modport slave (
    output pc_sel, pc_target, stall_d, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, valid_d, instr_d, pc_d, pc_next_d
  );

endinterface

// File: rtl/fetch_entry_queue.sv
// Circular buffer of in-flight fetches: alloc pointer for new requests, fill pointer for the
// oldest entry still waiting on memory, head pointer for the entry offered to decode.
module fetch_entry_queue
  import fetch_pkg::*;
#(
  parameter int unsigned  ADDR_W   = 32,
  parameter int unsigned  FQ_DEPTH = 4,
  localparam int unsigned IDX_W    = $clog2(FQ_DEPTH),
  localparam int unsigned PTR_W    = IDX_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_en,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill_en,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               deq_en,
  output logic [PTR_W-1:0]   count,
  output logic [PTR_W-1:0]   unfilled,
  output logic               head_filled,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc
);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(FQ_DEPTH);

  logic [PTR_W-1:0]  alloc_ptr_r;
  logic [PTR_W-1:0]  fill_ptr_r;
  logic [PTR_W-1:0]  head_ptr_r;
  fq_entry_t         slot_r [FQ_DEPTH];
  logic [ADDR_W-1:0] pc_r   [FQ_DEPTH];

  logic [IDX_W-1:0]  alloc_idx_s;
  logic [IDX_W-1:0]  fill_idx_s;
  logic [IDX_W-1:0]  head_idx_s;
  logic              alloc_ok_s;
  logic              fill_ok_s;
  logic              deq_ok_s;

  // Pointers carry one wrap bit so full and empty are distinguishable by subtraction.
  assign alloc_idx_s = alloc_ptr_r[IDX_W-1:0];
  assign fill_idx_s  = fill_ptr_r[IDX_W-1:0];
  assign head_idx_s  = head_ptr_r[IDX_W-1:0];

  assign count       = alloc_ptr_r - head_ptr_r;
  assign unfilled    = alloc_ptr_r - fill_ptr_r;
  assign head_filled = (count != '0) && slot_r[head_idx_s].filled;
  assign head_instr  = slot_r[head_idx_s].instr;
  assign head_pc     = pc_r[head_idx_s];

  // Guard each operation against illegal requests so a misbehaving caller cannot corrupt the ring.
  always_comb begin
    alloc_ok_s = alloc_en && (count != PTR_FULL);
    fill_ok_s  = fill_en && (unfilled != '0);
    deq_ok_s   = deq_en && head_filled;
  end

  // Pointer advance; flush returns the ring to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
    end else if (flush) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
    end else begin
      if (alloc_ok_s) begin
        alloc_ptr_r <= alloc_ptr_r + PTR_W'(1'b1);
      end
      if (fill_ok_s) begin
        fill_ptr_r <= fill_ptr_r + PTR_W'(1'b1);
      end
      if (deq_ok_s) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1'b1);
      end
    end
  end

  // Slot payload; alloc, fill and dequeue never target the same slot in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r <= '{default: '0};
    end else if (flush) begin
      slot_r <= '{default: '0};
    end else begin
      if (alloc_ok_s) begin
        slot_r[alloc_idx_s] <= '{instr: NOP_INSTR, filled: 1'b0};
      end
      if (fill_ok_s) begin
        slot_r[fill_idx_s].instr  <= fill_data;
        slot_r[fill_idx_s].filled <= 1'b1;
      end
      if (deq_ok_s) begin
        slot_r[head_idx_s].filled <= 1'b0;
      end
    end
  end

  // Slot PCs are written at allocation only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= '{default: '0};
    end else if (alloc_ok_s && !flush) begin
      pc_r[alloc_idx_s] <= alloc_pc;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: fetch PC, redirect handling with stale-response dropping,
// and the handoff of in-order fetched words to decode.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_unit_if.master fq
);

  localparam int unsigned       PTR_W      = $clog2(FQ_DEPTH) + 1;
  localparam logic [PTR_W:0]    DEPTH_W    = (PTR_W + 1)'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_WORD = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] INCR_W     = ADDR_W'(PC_INCR);

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [PTR_W-1:0]   drop_cnt_r;

  logic [PTR_W-1:0]   count_s;
  logic [PTR_W-1:0]   unfilled_s;
  logic [PTR_W-1:0]   outstanding_s;
  logic [PTR_W-1:0]   drop_next_s;
  logic               head_filled_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic [ADDR_W-1:0]  head_pc_s;
  logic               room_s;
  logic               req_valid_s;
  logic               req_fire_s;
  logic               drop_rsp_s;
  logic               fill_s;
  logic               valid_d_s;
  logic               deq_s;

  fetch_entry_queue #(
    .ADDR_W   (ADDR_W),
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (fq.pc_sel),
    .alloc_en    (req_fire_s),
    .alloc_pc    (fetch_pc_r),
    .fill_en     (fill_s),
    .fill_data   (fq.imem_rsp_data),
    .deq_en      (deq_s),
    .count       (count_s),
    .unfilled    (unfilled_s),
    .head_filled (head_filled_s),
    .head_instr  (head_instr_s),
    .head_pc     (head_pc_s)
  );

  // Handshake decisions. Responses still owed to flushed requests occupy queue budget until they return.
  always_comb begin
    room_s        = ({1'b0, count_s} + {1'b0, drop_cnt_r}) < DEPTH_W;
    req_valid_s   = rst && room_s && !fq.pc_sel;
    req_fire_s    = req_valid_s && fq.imem_req_ready;
    drop_rsp_s    = fq.imem_rsp_valid && (drop_cnt_r != '0);
    fill_s        = fq.imem_rsp_valid && (drop_cnt_r == '0) && !fq.pc_sel;
    valid_d_s     = head_filled_s && !fq.pc_sel;
    deq_s         = valid_d_s && !fq.stall_d;
    outstanding_s = drop_cnt_r + unfilled_s;
    if (fq.imem_rsp_valid && (outstanding_s != '0)) begin
      drop_next_s = outstanding_s - PTR_W'(1'b1);
    end else begin
      drop_next_s = outstanding_s;
    end
  end

  // Fetch PC: redirect wins, otherwise advance one word per accepted request (wraps naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_WORD;
    end else if (fq.pc_sel) begin
      fetch_pc_r <= {fq.pc_target[ADDR_W-1:2], 2'b00};
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + INCR_W;
    end
  end

  // Responses owed to flushed requests; a redirect while dropping keeps the earlier debt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_r <= '0;
    end else if (fq.pc_sel) begin
      drop_cnt_r <= drop_next_s;
    end else if (drop_rsp_s) begin
      drop_cnt_r <= drop_cnt_r - PTR_W'(1'b1);
    end
  end

  assign fq.imem_req_valid = req_valid_s;
  assign fq.imem_req_addr  = fetch_pc_r;
  assign fq.valid_d        = valid_d_s;
  assign fq.instr_d        = valid_d_s ? head_instr_s : NOP_INSTR;
  assign fq.pc_d           = valid_d_s ? head_pc_s : '0;
  assign fq.pc_next_d      = valid_d_s ? (head_pc_s + INCR_W) : '0;

endmodule
